sync_dual_port_mem: RTL
=======================

Name: sync_dual_port_mem

Overview:
Parametrised unified memory for the CPU. It has one data port (read/write with byte mask) and one read-only instruction-fetch port. Both reads are synchronous, pipelined, with a fixed programmable latency and valid strobes. After reset, a sequencer clears the whole array, and `init_done` gates the core until the clear completes.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 16, address width; DEPTH = 2**ADDR_W words.
- RD_LATENCY, 1, cycles from accepted read request to `*_rvalid`; legal 1..4.
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = skip the clear.
- WRITE_FIRST, 0, same-address read/write collision policy: 0 = old data, 1 = new data.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_done  out  1  high once the clear sequence has finished; requests are accepted only while high.
- d_req  in  1  data-port request.
- d_we  in  1  1 = write, 0 = read (qualified by `d_req`).
- d_addr  in  ADDR_W  data-port word address.
- d_wdata  in  DATA_W  write data.
- d_wmask  in  DATA_W/8  byte enables for a write; bit i enables byte i.
- d_rdata  out  DATA_W  data-port read result.
- d_rvalid  out  1  one-cycle strobe: `d_rdata` is valid.
- f_req  in  1  fetch request.
- f_addr  in  ADDR_W  fetch address (the PC).
- f_rdata  out  DATA_W  fetched instruction word.
- f_rvalid  out  1  one-cycle strobe: `f_rdata` is valid.

Behaviour:
- Reset values: `init_done` = 0, `d_rvalid` = 0, `f_rvalid` = 0, `d_rdata` = 0, `f_rdata` = 0.
- Reset flushes all read pipeline stages and returns the FSM to CLEAR with the clear counter at 0.
- The array contents are not reset.
- FSM has two states:
  - CLEAR: each cycle writes 0 to `mem[cnt]` and increments `cnt`. When `cnt` reaches DEPTH-1, that word is written and the FSM moves to READY. Clear time is exactly DEPTH cycles. If INIT_CLEAR=0, CLEAR lasts exactly 1 cycle and writes nothing.
  - READY: `init_done` = 1. The FSM stays in READY until `rst`.
- Request gating: in CLEAR, `d_req` and `f_req` are ignored: no write occurs and no valid strobe is produced.
- A request is accepted in the cycle `*_req` = 1 and `init_done` = 1. There is no backpressure; both ports accept one request every cycle.
- Write: `mem[d_addr]` byte i is updated with `d_wdata` byte i wherever `d_wmask[i]` = 1, on the accepting edge. A write produces no `d_rvalid`.
- Read:
  - The array is sampled on the accepting edge.
  - The result travels through a (RD_LATENCY-1)-deep register pipeline.
  - `*_rvalid` pulses high for exactly one cycle, RD_LATENCY cycles after acceptance. For RD_LATENCY=1 that is the cycle immediately following the accepting edge.
  - `*_rdata` updates only on a valid strobe and holds its value otherwise.
  - Back-to-back requests produce back-to-back strobes, in order.
- Collision (data write and fetch read to the same address in the same cycle):
  - WRITE_FIRST=0: the fetch returns the pre-write word.
  - WRITE_FIRST=1: the fetch returns the post-write (masked-merged) word.
- Two requests on the data port cannot collide with each other, since it carries one operation per cycle.
- Address wrap: addresses are ADDR_W bits, so no out-of-range access exists. During the clear, the counter stops at DEPTH-1 and does not wrap.
- Reset mid-operation: read requests already in the pipeline are discarded, and no `*_rvalid` is produced for them after reset. A clear that is in progress restarts from address 0.

Optional Feature:
- Macro: `MEM_PARITY_EN`.
- When defined:
  - Each word stores one extra even-parity bit, computed over the post-merge word.
  - The clear writes parity 0.
  - New outputs `d_perr` and `f_perr` (1 bit each, reset 0) are asserted together with the matching `*_rvalid` when the stored parity mismatches the stored data.
  - Partial-mask writes recompute parity over the full merged word.
- When undefined: no parity storage, and the `d_perr`/`f_perr` ports do not exist.

Test Plan (ADDR_W=4, DATA_W=16 unless stated):
1. Clear sequence:
   - Stimulus: release `rst`.
   - Required: `init_done` rises after exactly 16 cycles; a fetch from every address 0..15 returns 0x0000.
   - Also: a `d_req` write issued during CLEAR has no effect.
2. Write then read:
   - Stimulus: write 0xBEEF to addr 3 with mask 2'b11, then read addr 3.
   - Required: `d_rvalid` pulses and `d_rdata` = 0xBEEF.
   - Then write 0x1200 with mask 2'b10 and read again: `d_rdata` = 0x12EF.
3. Latency sweep:
   - Stimulus: for RD_LATENCY = 1, 2, 4, issue fetches at addrs 5, 6, 7 on consecutive cycles (preloaded 0x0005..0x0007).
   - Required: `f_rvalid` is high for 3 consecutive cycles starting exactly RD_LATENCY cycles after the first request; data arrives in order.
4. Collision:
   - Stimulus: addr 9 holds 0x1111; in one cycle, write 0x2222 to addr 9 and fetch addr 9.
   - Required: `f_rdata` = 0x1111 with WRITE_FIRST=0, and 0x2222 with WRITE_FIRST=1.
5. Reset mid-read:
   - Stimulus: RD_LATENCY=3; accept a fetch, then assert `rst` on the next cycle.
   - Required: no `f_rvalid` afterwards; `init_done` = 0 and the clear restarts at address 0.
6. Parity (`MEM_PARITY_EN`):
   - Stimulus: write 0x0001 and read it back.
   - Required: `d_perr` = 0.
   - Then force-flip a stored data bit and read: `d_perr` = 1 in the same cycle as `d_rvalid`.

Source files
------------

// File: rtl/sync_dual_port_mem.sv
// Unified memory: byte-masked data port plus read-only fetch port.
// Optional per-word even parity when MEM_PARITY_EN is defined.
module sync_dual_port_mem #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int RD_LATENCY  = 1,
   parameter int INIT_CLEAR  = 1,
   parameter int WRITE_FIRST = 0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                init_done,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_rvalid,
   input  logic                f_req,
   input  logic [ADDR_W-1:0]   f_addr,
   output logic [DATA_W-1:0]   f_rdata,
   output logic                f_rvalid
`ifdef MEM_PARITY_EN
   ,
   output logic                d_perr,
   output logic                f_perr
`endif
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;
`ifdef MEM_PARITY_EN
   localparam int SW = DATA_W + 1;
`else
   localparam int SW = DATA_W;
`endif

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;

   logic [SW-1:0]     mem [DEPTH];

   logic              clr_we;
   logic              d_wr, d_rd, f_rd;
   logic [DATA_W-1:0] wmerge;
   logic [SW-1:0]     wword;
   logic [SW-1:0]     f_word;

   logic [RD_LATENCY-1:0] dv, fv;
   logic [SW-1:0]         dd [RD_LATENCY];
   logic [SW-1:0]         fd [RD_LATENCY];

   // Stored word: data plus (optionally) its even-parity bit on top
   function automatic logic [SW-1:0] enc(input logic [DATA_W-1:0] w);
`ifdef MEM_PARITY_EN
      return {^w, w};
`else
      return w;
`endif
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= CLEAR;
         cnt       <= '0;
         init_done <= 1'b0;
      end else if (state == CLEAR) begin
         if (INIT_CLEAR == 0 || &cnt) begin
            state     <= READY;
            init_done <= 1'b1;
         end else begin
            cnt <= cnt + ADDR_W'(1);
         end
      end
   end

   assign clr_we = ~rst && state == CLEAR && INIT_CLEAR != 0;
   assign d_wr   = d_req & init_done & d_we;
   assign d_rd   = d_req & init_done & ~d_we;
   assign f_rd   = f_req & init_done;

   always_comb begin
      wmerge = mem[d_addr][DATA_W-1:0];
      for (int i = 0; i < NB; i++) begin
         if (d_wmask[i]) wmerge[8*i +: 8] = d_wdata[8*i +: 8];
      end
   end

   assign wword = enc(wmerge);

   always_comb begin
      f_word = mem[f_addr];
      if (WRITE_FIRST != 0 && d_wr && d_addr == f_addr) f_word = wword;
   end

   always_ff @(posedge clk) begin
      if (clr_we)    mem[cnt]    <= '0;
      else if (d_wr) mem[d_addr] <= wword;
   end

   // Stage data only moves with its valid, so the last stage holds the last result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dv <= '0;
         fv <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            dd[i] <= '0;
            fd[i] <= '0;
         end
      end else begin
         dv[0] <= d_rd;
         fv[0] <= f_rd;
         if (d_rd) dd[0] <= mem[d_addr];
         if (f_rd) fd[0] <= f_word;
         for (int i = 1; i < RD_LATENCY; i++) begin
            dv[i] <= dv[i-1];
            fv[i] <= fv[i-1];
            if (dv[i-1]) dd[i] <= dd[i-1];
            if (fv[i-1]) fd[i] <= fd[i-1];
         end
      end
   end

   assign d_rvalid = dv[RD_LATENCY-1];
   assign f_rvalid = fv[RD_LATENCY-1];
   assign d_rdata  = dd[RD_LATENCY-1][DATA_W-1:0];
   assign f_rdata  = fd[RD_LATENCY-1][DATA_W-1:0];

`ifdef MEM_PARITY_EN
   assign d_perr = dv[RD_LATENCY-1] & ^dd[RD_LATENCY-1];
   assign f_perr = fv[RD_LATENCY-1] & ^fd[RD_LATENCY-1];
`endif

endmodule
